bht_update_queue: RTL and testbench
===================================

BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries; a power of two, at least 2.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the drop counter.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1: synchronous clear of all queued entries.
REQ-006 SHALL have port debug_mode_i, input, 1: while high, the queue neither accepts nor issues entries.
REQ-007 SHALL have port hold_i, input, 1: while high, the queue stalls issue to the predictor.
REQ-008 SHALL have port resolved_valid_i, input, 1: a branch has resolved this cycle.
REQ-009 SHALL have port resolved_pc_i, input, riscv::VLEN: PC of the resolved branch.
REQ-010 SHALL have port resolved_taken_i, input, 1: actual outcome of the resolved branch.
REQ-011 SHALL have port bht_update_o, output, ariane_pkg::bht_update_t (valid, pc, taken): the update sent to the branch history table.
REQ-012 SHALL have port full_o, output, 1: the queue holds DEPTH entries.
REQ-013 SHALL have port empty_o, output, 1: the queue holds 0 entries.
REQ-014 SHALL have port drop_cnt_o, output, CNT_WIDTH: count of resolved branches lost to overflow.

Function
REQ-015 SHALL store entries {pc, taken} in a circular FIFO with read pointer, write pointer and occupancy count; occupancy ranges 0..DEPTH.
REQ-016 SHALL define pop = !empty && !hold_i && !debug_mode_i && !flush_i.
REQ-017 SHALL drive bht_update_o.valid = pop, with bht_update_o.pc and .taken taken from the head entry; the pop takes effect at the same clock edge.
REQ-018 SHALL define push = resolved_valid_i && !debug_mode_i && !flush_i && (!full || pop).
REQ-019 SHALL give a minimum latency of 1 cycle: an entry written at edge N is issuable in the cycle after N. There is no input-to-output bypass.
REQ-020 SHALL issue entries strictly in arrival order, one per cycle at most.
REQ-021 SHALL, when push and pop occur together, keep occupancy unchanged and advance both pointers; this includes the full case, where the new entry is accepted.
REQ-022 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-023 SHALL treat a drop as resolved_valid_i && !debug_mode_i && !flush_i && full && !pop.
REQ-024 SHALL increment drop_cnt_o by 1 on each drop, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-025 SHALL, on flush_i high, set both pointers and occupancy to 0 at the next edge and discard any resolved input that cycle; bht_update_o.valid is 0 in that cycle.
REQ-026 SHALL leave drop_cnt_o unchanged on flush.
REQ-027 SHALL, while debug_mode_i is high, ignore resolved inputs (not counted as drops) and keep stored entries intact; issue resumes when debug_mode_i falls.
REQ-028 SHALL, while hold_i is high, retain all entries; pushes continue and drops are counted normally.
REQ-029 SHALL drive full_o = (occupancy == DEPTH) and empty_o = (occupancy == 0), both taken from registered state.
REQ-030 SHALL give flush_i priority over debug_mode_i, which has priority over hold_i.

Reset
REQ-031 SHALL, on rst_ni low, asynchronously clear pointers, occupancy and drop_cnt_o to 0; after reset empty_o=1, full_o=0 and bht_update_o.valid=0.
REQ-032 SHALL leave entry payload storage uninitialised by reset; payload is never observable while the queue is empty.
REQ-033 SHALL, if reset is asserted mid-operation, lose all queued entries with no partial issue after reset release.

Verification
REQ-034 SHALL cover single entry: push pc=0x80, taken=1 at cycle 0 -> bht_update_o={1,0x80,1} in cycle 1 only, then empty_o=1.
REQ-035 SHALL cover overflow: DEPTH=4, hold_i=1, 6 pushes -> full_o=1, drop_cnt_o=2; release hold -> the first 4 PCs issue in order over 4 cycles.
REQ-036 SHALL cover full with simultaneous push and pop: full queue, hold_i=0, push X -> no drop, occupancy stays 4, X issues 4 cycles later.
REQ-037 SHALL cover flush: 3 entries queued, flush_i=1 with resolved_valid_i=1 -> no issue that cycle, next cycle empty_o=1, drop_cnt_o unchanged.
REQ-038 SHALL cover debug: 2 entries queued, debug_mode_i=1 for 5 cycles with pushes -> no output, no drops; after debug falls exactly 2 entries issue.
REQ-039 SHALL cover drop counter saturation: CNT_WIDTH=2, 5 drops -> drop_cnt_o=3.

Source files
------------

// File: rtl/bht_update_queue.sv
// Branch-history-table update queue: buffers resolved branches and issues them
// in order, one per cycle, to the BHT; counts branches lost to overflow.
package bht_update_queue_pkg;

    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

endpackage

module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 debug_mode_i,
    input  logic                 hold_i,
    input  logic                 resolved_valid_i,
    input  logic [VLEN-1:0]      resolved_pc_i,
    input  logic                 resolved_taken_i,
    output bht_update_t          bht_update_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [OCC_W-1:0]     occ;
    logic [CNT_WIDTH-1:0] drop_cnt;

    logic [VLEN-1:0] pc_mem    [DEPTH];
    logic            taken_mem [DEPTH];

    logic full;
    logic empty;
    logic accept;
    logic pop;
    logic push;
    logic drop;

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);

    // flush outranks debug, debug outranks hold; a full queue still accepts
    // when the head leaves in the same cycle
    always_comb begin
        accept = !flush_i && !debug_mode_i;
        pop    = !empty && !hold_i && accept;
        push   = resolved_valid_i && accept && (!full || pop);
        drop   = resolved_valid_i && accept && full && !pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    // payload is only visible behind a non-empty occupancy, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resolved_pc_i;
            taken_mem[wr_ptr] <= resolved_taken_i;
        end
    end

    always_comb begin
        bht_update_o       = '0;
        bht_update_o.valid = pop;
        bht_update_o.pc    = pc_mem[rd_ptr];
        bht_update_o.taken = taken_mem[rd_ptr];
    end

    assign full_o     = full;
    assign empty_o    = empty;
    assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_bht_update_queue.sv
// Bench for bht_update_queue: directed vector table plus a queue-based
// reference model checked every cycle, on a default and a 2-bit-counter instance.
module tb_bht_update_queue;
    import bht_update_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        dbg;
    logic        hold;
    logic        rv;
    logic [63:0] rpc;
    logic        rtk;

    bht_update_t upd;
    logic        full;
    logic        empty;
    logic [7:0]  drop_cnt;

    bht_update_t upd_sat;
    logic        full_sat;
    logic        empty_sat;
    logic [1:0]  drop_sat;

    always #5 clk = ~clk;

    bht_update_queue #(.DEPTH(DEPTH), .CNT_WIDTH(8)) u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .debug_mode_i     (dbg),
        .hold_i           (hold),
        .resolved_valid_i (rv),
        .resolved_pc_i    (rpc),
        .resolved_taken_i (rtk),
        .bht_update_o     (upd),
        .full_o           (full),
        .empty_o          (empty),
        .drop_cnt_o       (drop_cnt)
    );

    bht_update_queue #(.DEPTH(DEPTH), .CNT_WIDTH(2)) u_sat (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .debug_mode_i     (dbg),
        .hold_i           (hold),
        .resolved_valid_i (rv),
        .resolved_pc_i    (rpc),
        .resolved_taken_i (rtk),
        .bht_update_o     (upd_sat),
        .full_o           (full_sat),
        .empty_o          (empty_sat),
        .drop_cnt_o       (drop_sat)
    );

    typedef struct {
        logic        f, d, h, rv;
        logic [63:0] pc;
        logic        tk;
        logic        e_valid;
        logic [63:0] e_pc;
        logic        e_tk;
        logic        e_full, e_empty;
        int          e_drop;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic        tk;
    } entry_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    entry_t mq[$];
    int     exp_drop = 0;
    int     exp_drop_sat = 0;
    vec_t   tab[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic f, d, h, r, input logic [63:0] pc, input logic tk,
                                input logic ev, input logic [63:0] epc, input logic etk,
                                input logic efull, eempty, input int edrop);
        vec_t v;
        v.f = f; v.d = d; v.h = h; v.rv = r; v.pc = pc; v.tk = tk;
        v.e_valid = ev; v.e_pc = epc; v.e_tk = etk;
        v.e_full = efull; v.e_empty = eempty; v.e_drop = edrop;
        return v;
    endfunction

    // drive one cycle's inputs, check both DUTs against the model, advance the model
    task automatic step(input logic f, d, h, r, input logic [63:0] pc, input logic tk);
        logic   mpop;
        entry_t e;
        @(negedge clk);
        flush = f; dbg = d; hold = h; rv = r; rpc = pc; rtk = tk;
        #1;
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("drop_cnt_sat", 64'(drop_sat), 64'(exp_drop_sat));
        mpop = (mq.size() != 0) && !h && !d && !f;
        chk("valid", 64'(upd.valid), 64'(mpop));
        chk("valid_sat", 64'(upd_sat.valid), 64'(mpop));
        if (mpop) begin
            e = mq.pop_front();
            chk("pc", upd.pc, e.pc);
            chk("taken", 64'(upd.taken), 64'(e.tk));
        end
        if (r && !f && !d) begin
            if (mq.size() < DEPTH) begin
                e.pc = pc; e.tk = tk;
                mq.push_back(e);
            end else begin
                if (exp_drop < 255) exp_drop++;
                if (exp_drop_sat < 3) exp_drop_sat++;
            end
        end
        if (f) mq.delete();
    endtask

    task automatic apply(input vec_t v);
        step(v.f, v.d, v.h, v.rv, v.pc, v.tk);
        chk("tab_valid", 64'(upd.valid), 64'(v.e_valid));
        if (v.e_valid) begin
            chk("tab_pc", upd.pc, v.e_pc);
            chk("tab_taken", 64'(upd.taken), 64'(v.e_tk));
        end
        chk("tab_full", 64'(full), 64'(v.e_full));
        chk("tab_empty", 64'(empty), 64'(v.e_empty));
        chk("tab_drop", 64'(drop_cnt), 64'(v.e_drop));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 0; dbg = 0; hold = 0; rv = 0; rpc = '0; rtk = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid", 64'(upd.valid), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //                f  d  h  rv pc        tk   ev epc       etk full empty drop
        // single entry
        tab.push_back(mk(0, 0, 0, 1, 64'h80,  1,   0, 64'h0,   0,  0,   1,    0));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h80,  1,  0,   0,    0));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   0, 64'h0,   0,  0,   1,    0));
        // overflow under hold, then drain in order
        tab.push_back(mk(0, 0, 1, 1, 64'h100, 0,   0, 64'h0,   0,  0,   1,    0));
        tab.push_back(mk(0, 0, 1, 1, 64'h110, 1,   0, 64'h0,   0,  0,   0,    0));
        tab.push_back(mk(0, 0, 1, 1, 64'h120, 0,   0, 64'h0,   0,  0,   0,    0));
        tab.push_back(mk(0, 0, 1, 1, 64'h130, 1,   0, 64'h0,   0,  0,   0,    0));
        tab.push_back(mk(0, 0, 1, 1, 64'h140, 0,   0, 64'h0,   0,  1,   0,    0));
        tab.push_back(mk(0, 0, 1, 1, 64'h150, 1,   0, 64'h0,   0,  1,   0,    1));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h100, 0,  1,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h110, 1,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h120, 0,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h130, 1,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   0, 64'h0,   0,  0,   1,    2));
        // full queue with simultaneous push and pop
        tab.push_back(mk(0, 0, 1, 1, 64'h200, 1,   0, 64'h0,   0,  0,   1,    2));
        tab.push_back(mk(0, 0, 1, 1, 64'h210, 0,   0, 64'h0,   0,  0,   0,    2));
        tab.push_back(mk(0, 0, 1, 1, 64'h220, 1,   0, 64'h0,   0,  0,   0,    2));
        tab.push_back(mk(0, 0, 1, 1, 64'h230, 0,   0, 64'h0,   0,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 1, 64'h240, 1,   1, 64'h200, 1,  1,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h210, 0,  1,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h220, 1,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h230, 0,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h240, 1,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   0, 64'h0,   0,  0,   1,    2));
        // flush with a resolved branch in the same cycle
        tab.push_back(mk(0, 0, 1, 1, 64'h300, 1,   0, 64'h0,   0,  0,   1,    2));
        tab.push_back(mk(0, 0, 1, 1, 64'h310, 1,   0, 64'h0,   0,  0,   0,    2));
        tab.push_back(mk(0, 0, 1, 1, 64'h320, 1,   0, 64'h0,   0,  0,   0,    2));
        tab.push_back(mk(1, 0, 0, 1, 64'h330, 1,   0, 64'h0,   0,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   0, 64'h0,   0,  0,   1,    2));
        // debug mode freezes the queue and ignores resolves
        tab.push_back(mk(0, 0, 1, 1, 64'h400, 0,   0, 64'h0,   0,  0,   1,    2));
        tab.push_back(mk(0, 0, 1, 1, 64'h410, 1,   0, 64'h0,   0,  0,   0,    2));
        for (int unsigned i = 0; i < 5; i++)
            tab.push_back(mk(0, 1, 0, 1, 64'h500 + 64'(i), 1, 0, 64'h0, 0, 0, 0, 2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h400, 0,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   1, 64'h410, 1,  0,   0,    2));
        tab.push_back(mk(0, 0, 0, 0, 64'h0,   0,   0, 64'h0,   0,  0,   1,    2));

        foreach (tab[i]) apply(tab[i]);

        // reset in the middle of operation discards queued entries
        step(0, 0, 1, 1, 64'h600, 1);
        step(0, 0, 1, 1, 64'h610, 0);
        @(negedge clk);
        flush = 0; dbg = 0; hold = 0; rv = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_valid", 64'(upd.valid), 64'd0);
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        mq.delete(); exp_drop = 0; exp_drop_sat = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 0, 64'h0, 0);

        // 2-bit drop counter saturation: fill, then five drops
        for (int unsigned i = 0; i < 9; i++) step(0, 0, 1, 1, 64'h700 + 64'(i), i[0]);
        step(0, 0, 1, 0, 64'h0, 0);
        chk("sat_drop", 64'(drop_sat), 64'd3);
        chk("sat_drop_wide", 64'(drop_cnt), 64'd5);
        for (int unsigned i = 0; i < 5; i++) step(0, 0, 0, 0, 64'h0, 0);

        // randomized traffic against the model
        for (int unsigned i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
